// File: rtl/lms_tap_sched.sv
// LMS tap sequencer: walks the tap index through an FIR phase and an optional
// weight-update phase per accepted sample, with pipeline drains and a delayed
// weight-write strobe. All outputs come straight from flops.
module lms_tap_sched #(
  parameter int unsigned TAPS = 128,
  parameter int unsigned PIPE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     adapt_en,
  input  logic                     ovr_clr,
  output logic [$clog2(TAPS)-1:0]  tap_addr,
  output logic                     mac_clr,
  output logic                     mac_en,
  output logic                     upd_en,
  output logic                     phase,
  output logic                     wt_we,
  output logic [$clog2(TAPS)-1:0]  wt_addr,
  output logic                     out_valid,
  output logic                     done,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned AW = $clog2(TAPS);
  localparam int unsigned DW = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
  localparam logic [DW-1:0] LAST_DRN = DW'(PIPE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FIR, S_FIR_DRAIN, S_UPD, S_UPD_DRAIN, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [DW-1:0]           dcnt_q, dcnt_d;
  logic                    adapt_q, adapt_d;
  logic                    overrun_q, overrun_d;
  logic [AW-1:0]           tap_addr_q, tap_addr_d;
  logic                    mac_clr_q, mac_clr_d;
  logic                    mac_en_q, mac_en_d;
  logic                    upd_en_q, upd_en_d;
  logic                    phase_q, phase_d;
  logic                    out_valid_q, out_valid_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic [PIPE-1:0]         we_pipe_q, we_pipe_d;
  logic [PIPE-1:0][AW-1:0] wa_pipe_q, wa_pipe_d;
  logic                    ovr_evt;

  // Next-state, sequencing counters and registered output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    adapt_d     = adapt_q;
    out_valid_d = 1'b0;
    ovr_evt     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (in_valid) begin
          state_d = S_FIR;
          cnt_d   = '0;
          adapt_d = adapt_en;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_FIR: begin
        ovr_evt = in_valid;
        if (cnt_q == LAST_TAP) begin
          state_d = S_FIR_DRAIN;
          dcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_FIR_DRAIN: begin
        ovr_evt = in_valid;
        if (dcnt_q == LAST_DRN) begin
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = adapt_q ? S_UPD : S_DONE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_UPD: begin
        ovr_evt = in_valid;
        if (cnt_q == LAST_TAP) begin
          state_d = S_UPD_DRAIN;
          dcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_UPD_DRAIN: begin
        ovr_evt = in_valid;
        if (dcnt_q == LAST_DRN) begin
          state_d = S_DONE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new overrun event wins over a simultaneous clear
    overrun_d  = ovr_evt | (overrun_q & ~ovr_clr);

    tap_addr_d = ((state_d == S_FIR) || (state_d == S_UPD)) ? cnt_d : '0;
    mac_en_d   = (state_d == S_FIR);
    mac_clr_d  = (state_d == S_FIR) && (cnt_d == '0);
    upd_en_d   = (state_d == S_UPD);
    phase_d    = (state_d == S_UPD) || (state_d == S_UPD_DRAIN);
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  // Write strobe/address delay line, PIPE stages behind the update strobe
  always_comb begin
    we_pipe_d    = we_pipe_q;
    wa_pipe_d    = wa_pipe_q;
    we_pipe_d[0] = upd_en_q;
    wa_pipe_d[0] = upd_en_q ? tap_addr_q : '0;
    for (int i = 1; i < int'(PIPE); i++) begin
      we_pipe_d[i] = we_pipe_q[i-1];
      wa_pipe_d[i] = wa_pipe_q[i-1];
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      adapt_q     <= 1'b0;
      overrun_q   <= 1'b0;
      tap_addr_q  <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      upd_en_q    <= 1'b0;
      phase_q     <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      we_pipe_q   <= '0;
      wa_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      adapt_q     <= adapt_d;
      overrun_q   <= overrun_d;
      tap_addr_q  <= tap_addr_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      upd_en_q    <= upd_en_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      we_pipe_q   <= we_pipe_d;
      wa_pipe_q   <= wa_pipe_d;
    end
  end

  assign tap_addr  = tap_addr_q;
  assign mac_clr   = mac_clr_q;
  assign mac_en    = mac_en_q;
  assign upd_en    = upd_en_q;
  assign phase     = phase_q;
  assign wt_we     = we_pipe_q[PIPE-1];
  assign wt_addr   = wa_pipe_q[PIPE-1];
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_lms_tap_sched.sv
// Bench for lms_tap_sched: default (128/2) and small (8/1) instances share the
// same stimulus and are each compared every cycle against a cycle-offset model.
module tb_lms_tap_sched;

  logic clk = 1'b0;
  logic rst, in_valid, adapt_en, ovr_clr;

  logic [6:0] tap0, wa0;
  logic       mclr0, men0, upd0, ph0, we0, ov0, dn0, bsy0, ovr0;
  logic [2:0] tap1, wa1;
  logic       mclr1, men1, upd1, ph1, we1, ov1, dn1, bsy1, ovr1;

  always #5 clk = ~clk;

  lms_tap_sched #(.TAPS(128), .PIPE(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .adapt_en(adapt_en), .ovr_clr(ovr_clr),
    .tap_addr(tap0), .mac_clr(mclr0), .mac_en(men0), .upd_en(upd0), .phase(ph0),
    .wt_we(we0), .wt_addr(wa0), .out_valid(ov0), .done(dn0), .busy(bsy0), .overrun(ovr0)
  );

  lms_tap_sched #(.TAPS(8), .PIPE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .adapt_en(adapt_en), .ovr_clr(ovr_clr),
    .tap_addr(tap1), .mac_clr(mclr1), .mac_en(men1), .upd_en(upd1), .phase(ph1),
    .wt_we(we1), .wt_addr(wa1), .out_valid(ov1), .done(dn1), .busy(bsy1), .overrun(ovr1)
  );

  // Model: k = cycles since the accepting edge (k=1 is the first FIR cycle)
  int m_t[2] = '{128, 8};
  int m_p[2] = '{2, 1};
  bit m_act[2];
  int m_k[2];
  bit m_adp[2];
  bit m_ovr[2];

  int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;

  function automatic int end_k(int id);
    return m_adp[id] ? 2*m_t[id] + 2*m_p[id] + 1 : m_t[id] + m_p[id] + 1;
  endfunction

  function automatic bit in_rng(int v, int lo, int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  task automatic model_step(input int id, input bit iv, input bit ad, input bit oc, input bit r);
    bit at_end;
    if (r) begin
      m_act[id] = 0; m_ovr[id] = 0; m_adp[id] = 0; m_k[id] = 0;
      return;
    end
    at_end = m_act[id] && (m_k[id] == end_k(id));
    if (iv && m_act[id] && !at_end) m_ovr[id] = 1;
    else if (oc)                    m_ovr[id] = 0;
    if (iv && (!m_act[id] || at_end)) begin
      m_act[id] = 1; m_k[id] = 1; m_adp[id] = ad;
    end else if (m_act[id]) begin
      if (at_end) m_act[id] = 0;
      else        m_k[id]++;
    end
  endtask

  // Expected {tap[7:0], wt_addr[7:0], mac_clr, mac_en, upd_en, phase, wt_we, out_valid, done, busy, overrun}
  function automatic logic [24:0] expv(int id);
    int t, p, k, tap, wa;
    bit a, mc, me, ue, ph, we, ov, dn;
    t = m_t[id]; p = m_p[id]; k = m_k[id]; a = m_adp[id];
    if (!m_act[id]) return {8'd0, 8'd0, 8'd0, m_ovr[id]};
    me  = in_rng(k, 1, t);
    mc  = (k == 1);
    ue  = a && in_rng(k, t+p+1, 2*t+p);
    ph  = a && in_rng(k, t+p+1, 2*t+2*p);
    we  = a && in_rng(k, t+2*p+1, 2*t+2*p);
    ov  = (k == t+p+1);
    dn  = (k == end_k(id));
    tap = me ? k-1 : (ue ? k-t-p-1 : 0);
    wa  = we ? k-t-2*p-1 : 0;
    return {8'(tap), 8'(wa), mc, me, ue, ph, we, ov, dn, 1'b1, m_ovr[id]};
  endfunction

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic step(input bit iv, input bit ad, input bit oc, input bit r);
    in_valid = iv; adapt_en = ad; ovr_clr = oc; rst = r;
    @(posedge clk);
    model_step(0, iv, ad, oc, r);
    model_step(1, iv, ad, oc, r);
    #1;
    cyc++;
    chk("dut128", {8'(tap0), 8'(wa0), mclr0, men0, upd0, ph0, we0, ov0, dn0, bsy0, ovr0}, expv(0));
    chk("dut8",   {8'(tap1), 8'(wa1), mclr1, men1, upd1, ph1, we1, ov1, dn1, bsy1, ovr1}, expv(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    in_valid = 0; adapt_en = 0; ovr_clr = 0; rst = 1;
    for (int i = 0; i < 2; i++) begin m_act[i] = 0; m_k[i] = 0; m_adp[i] = 0; m_ovr[i] = 0; end

    // Reset, with a sample offered during reset that must be ignored
    step(0, 0, 0, 1);
    step(1, 1, 0, 1);
    idle(3);

    // Full sequence with adaptation
    step(1, 1, 0, 0);
    idle(270);

    // Filter only
    step(1, 0, 0, 0);
    idle(140);

    // Overrun at 50, clear at 300
    step(1, 1, 0, 0);
    idle(49);
    step(1, 0, 0, 0);
    idle(249);
    step(0, 0, 1, 0);
    idle(5);

    // Back-to-back sample on the DONE cycle
    step(1, 1, 0, 0);
    idle(260);
    step(1, 1, 0, 0);
    idle(300);

    // Reset mid-update, then restart
    step(1, 1, 0, 0);
    idle(139);
    step(0, 0, 0, 1);
    idle(5);
    step(1, 1, 0, 0);
    idle(300);

    // Overrun and clear in the same cycle keeps the flag set
    step(1, 1, 0, 0);
    idle(20);
    step(1, 0, 1, 0);
    idle(3);
    step(0, 0, 1, 0);
    idle(300);

    // Randomized traffic
    for (int i = 0; i < 5000; i++) begin
      step(($urandom % 40) == 0, 1'($urandom), ($urandom % 50) == 0, ($urandom % 600) == 0);
    end
    idle(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lms_tap_sched.md
LMS_TAP_SCHED -- requirements
Module: lms_tap_sched

Interface
REQ-001 SHALL have parameter TAPS, default 128: filter length; the number of tap/weight slots sequenced per phase.
REQ-002 SHALL have parameter PIPE, default 2: MAC/weight-update pipeline latency in cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: new-sample strobe, one cycle.
REQ-006 SHALL have port adapt_en, input, 1 bit: enables the weight-update phase; sampled at sample acceptance.
REQ-007 SHALL have port ovr_clr, input, 1 bit: clears the overrun flag.
REQ-008 SHALL have port tap_addr, output, clog2(TAPS) bits: tap/weight read index.
REQ-009 SHALL have port mac_clr, output, 1 bit: clears the FIR accumulator, aligned with index 0.
REQ-010 SHALL have port mac_en, output, 1 bit: FIR multiply-accumulate enable.
REQ-011 SHALL have port upd_en, output, 1 bit: weight-update multiply enable.
REQ-012 SHALL have port phase, output, 1 bit: 0 = filter phase, 1 = update phase.
REQ-013 SHALL have port wt_we, output, 1 bit: weight write enable.
REQ-014 SHALL have port wt_addr, output, clog2(TAPS) bits: weight write index.
REQ-015 SHALL have port out_valid, output, 1 bit: FIR result ready, one-cycle pulse.
REQ-016 SHALL have port done, output, 1 bit: sample processing complete, one-cycle pulse.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port overrun, output, 1 bit: sticky flag for a sample that arrived while busy.

Function
REQ-019 SHALL implement the states IDLE, FIR, FIR_DRAIN, UPD, UPD_DRAIN and DONE, with every output registered.
REQ-020 SHALL accept in_valid only in IDLE or DONE, moving to FIR next cycle and latching adapt_en.
REQ-021 SHALL, in FIR, drive tap_addr 0..TAPS-1 on consecutive cycles with mac_en=1 and phase=0, and assert mac_clr only on the index-0 cycle.
REQ-022 SHALL, in FIR_DRAIN, hold mac_en=0 for exactly PIPE cycles.
REQ-023 SHALL pulse out_valid on the cycle after FIR_DRAIN: cycle TAPS+PIPE+1 after acceptance (131 at defaults).
REQ-024 SHALL go from FIR_DRAIN to UPD if latched adapt_en=1, otherwise to DONE.
REQ-025 SHALL, in UPD, drive tap_addr 0..TAPS-1 with upd_en=1 and phase=1, then spend PIPE cycles in UPD_DRAIN, then go to DONE.
REQ-026 SHALL make wt_we and wt_addr the upd_en and tap_addr values delayed by exactly PIPE cycles, so the last write lands on the last UPD_DRAIN cycle.
REQ-027 SHALL make DONE last one cycle with done=1, then go to IDLE, or to FIR if in_valid is high that cycle.
REQ-028 SHALL wrap tap_addr from TAPS-1 to 0 only through a phase change, never within a phase.
REQ-029 SHALL, for in_valid in FIR, FIR_DRAIN, UPD or UPD_DRAIN: ignore the sample, leave the sequence undisturbed and set overrun.
REQ-030 SHALL clear overrun on ovr_clr; if ovr_clr and an overrun event coincide, overrun SHALL remain set.
REQ-031 SHALL hold tap_addr and wt_addr at 0 and all strobes low in IDLE.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, enter IDLE with every output 0, including overrun, the latched adapt_en and the write-delay pipeline.
REQ-033 SHALL, on reset mid-sequence, abort the sequence with no further wt_we, out_valid or done.
REQ-034 SHALL ignore in_valid coinciding with rst.

Verification
REQ-035 Scenario: in_valid at cycle 0, adapt_en=1, defaults -> mac_clr at 1; tap_addr 0..127 over cycles 1..128; out_valid at 131; upd_en over 131..258; wt_we addr 0..127 over 133..260; done at 261; busy low at 262.
REQ-036 Scenario: adapt_en=0 -> out_valid and done both at 131; no upd_en or wt_we; IDLE at 132.
REQ-037 Scenario: second in_valid at 50 -> overrun=1 at 51; sequence timing identical to REQ-035; ovr_clr at 300 -> overrun=0 at 301.
REQ-038 Scenario: in_valid on the DONE cycle (261) -> FIR at 262 with mac_clr and tap_addr=0; no overrun.
REQ-039 Scenario: rst at cycle 140 (in UPD) -> all outputs 0 at 141; no wt_we afterwards; next in_valid restarts normally.
REQ-040 Scenario: TAPS=8, PIPE=1 -> out_valid at 10; done at 19.
